uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the core's Avalon-style peripheral port, directly downstream of the RISC-V core's MEM stage. It accepts byte writes at the display/console address into a small FIFO and serializes them as 8N1 frames on `tx`. It drives the core's pipeline-advance input (`av_ready`, high = proceed) low only when a write targets a full FIFO. Register reads return FIFO and transmitter status.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); minimum 2.
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `DATA_ADDR`, 32'h108: data register word address.
- `STAT_ADDR`, 32'h10C: status register word address.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `av_address`  in  32  byte/word address from the core's MEM-stage ALU result.
- `av_read_n`  in  1  active-low read strobe.
- `av_write_n`  in  1  active-low write strobe.
- `av_writedata`  in  32  write data; only [7:0] is used.
- `av_readdata`  out  32  read data; combinational.
- `av_ready`  out  1  core pipeline enable; low stalls every core stage.
- `tx`  out  1  serial output; idles high.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- **Write to DATA_ADDR, FIFO not full.** The write is accepted at the clock edge: `av_writedata[7:0]` is pushed and `av_ready` stays 1.
- **Write to DATA_ADDR, FIFO full.** `av_ready`=0 combinationally and nothing is pushed. The core holds its strobes, so the write is retried each cycle until a slot frees.
- **`av_ready` decode.** `av_ready` is computed from the registered `full` only. A pop on the same edge does not admit a write that cycle; the write is accepted on the following edge.
- **Writes to any other address.** Ignored; `av_ready`=1.
- **Read of DATA_ADDR.** Returns {24'b0, last accepted byte}.
- **Read of STAT_ADDR.** Returns {16'b0, count[7:0], 6'b0, full, tx_busy}.
- **Read of any other address, or no read.** `av_readdata`=0.
- **Simultaneous read and write.** Legal. The write follows the write rules above; the read returns pre-edge values.
- **FIFO structure.** Circular buffer with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits wide.
- **FIFO flags.** `full` = (count==DEPTH); `empty` = (count==0).
- **Same-edge push and pop.** `count` is unchanged; both pointers advance.
- **Transmitter FSM states:** IDLE, START, DATA, STOP. It uses a bit counter (3 bits) and a baud counter (log2(CLKS_PER_BIT) bits).
  - IDLE: `tx`=1. If `!empty`, pop the FIFO head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if `!empty`, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- `tx_busy` = (state!=IDLE) | !empty.
- **Reset** (any cycle, including mid-frame): state=IDLE, `tx`=1, pointers/count/last-byte=0, FIFO contents discarded, `av_ready`=1, `av_readdata`=0 (no strobe), `tx_busy`=0. The frame in progress is truncated, with `tx` high on the cycle after the reset edge.

## Timing
- `tx` is a registered output. `av_ready` and `av_readdata` are combinational from inputs and registered state. There are no combinational paths to `tx`.
- **Write-to-line latency.** If a write is accepted at edge E into an empty FIFO with the FSM idle, the FIFO is non-empty after E. At E+1 the FSM pops and enters START, and `tx` falls after E+1.
- **Frame length.** Exactly 10×CLKS_PER_BIT cycles from the `tx` falling edge to the end of STOP.
- **Stall throughput.** At most one FIFO push per cycle. Continuous back-to-back writes fill DEPTH entries, after which one write is admitted per frame.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles -> `tx`=1, `av_ready`=1, `tx_busy`=0. A read of STAT_ADDR returns 0.
- **Single byte** (CLKS_PER_BIT=4). Write 0xA5 to 0x108 -> `tx` falls 2 edges later. Sampled line is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `tx_busy` drops after 40 cycles.
- **Fill and stall** (DEPTH=8). Write 10 bytes 0x00..0x09 back-to-back -> `av_ready` goes low on the 10th write. The first pop occurs 1 cycle after the first write, so 9 are accepted before the stall. The stall is released one edge after the first frame ends. All 10 bytes appear on `tx` in order with no inter-frame gap.
- **Status read.** After 3 writes with the FSM mid-frame, a read of 0x10C -> count=2, `full`=0, bit0=1.
- **Ignored access.** Write 0xFF to 0x104 -> no push, count unchanged, `av_ready`=1, `tx` stays 1.
- **Reset mid-frame.** Assert `reset` during DATA bit 3 with 2 bytes queued -> `tx`=1 the next cycle, count=0, and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte writes queue into a small FIFO,
// the FSM serializes them on tx, and av_ready stalls the core only on a full FIFO.
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] DATA_ADDR    = 32'h108,
    parameter logic [31:0] STAT_ADDR    = 32'h10C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] av_address,
    input  logic        av_read_n,
    input  logic        av_write_n,
    input  logic [31:0] av_writedata,
    output logic [31:0] av_readdata,
    output logic        av_ready,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    last_q;

    logic full, empty, wr_hit, push, pop, baud_end;
    logic unused_wdata_hi;

    assign unused_wdata_hi = ^av_writedata[31:8];

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign wr_hit   = !av_write_n && (av_address == DATA_ADDR);
    // Stall decode looks at the registered full flag only, so a same-edge pop
    // admits the retried write one edge later.
    assign push     = wr_hit && !full;
    assign av_ready = !(wr_hit && full);
    assign baud_end = (baud_q == BAUD_LAST);
    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE) || !empty;

    always_comb begin
        av_readdata = '0;
        if (!av_read_n) begin
            if (av_address == DATA_ADDR)
                av_readdata = {24'b0, last_q};
            else if (av_address == STAT_ADDR)
                av_readdata = {16'b0, 8'(count_q), 6'b0, full, tx_busy};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= av_writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                last_q   <= av_writedata[7:0];
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Transmitter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decided from the upcoming state so tx stays a clean register.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule
